// File: rtl/mem_access_pkg.sv
// Shared definitions for the write-stage memory access unit: RV32 load/store
// width codes, the controller state encoding and request legality checks.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always fine.
  // Only funct3[1:0] matters because unsigned variants share the width field.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b01:   return lane[0];
      2'b10:   return (lane != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Both op bits set, or a width code the op does not support.
  function automatic logic is_illegal(input logic load, input logic store, input logic [2:0] funct3);
    if (load && store) return 1'b1;
    if (store) return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    if (load)  return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                        funct3 == F3_BU || funct3 == F3_HU);
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data/byte-enables toward memory and
// load-word lane selection plus sign/zero extension back toward the core.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [31:0] ld_shifted;

  // Store: replicate the narrow value into every lane and enable only the target bytes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << st_lane;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load: bring the addressed lane down to bit 0, then extend by width/sign code.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_lane, 3'b000};
    case (ld_funct3)
      F3_B:    ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_H:    ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_BU:   ld_value = {24'h000000, ld_shifted[7:0]};
      F3_HU:   ld_value = {16'h0000, ld_shifted[15:0]};
      default: ld_value = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Write-stage load/store unit driving a single-outstanding, variable-latency
// data bus. Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err
);

  state_t      state;
  logic        op_load;
  logic [2:0]  op_funct3;
  logic [1:0]  op_lane;
  logic [4:0]  op_rd;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_value;
  logic        bad_req;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign bad_req = is_illegal(req_load, req_store, req_funct3) ||
                   is_misaligned(req_funct3, req_addr[1:0]);

  // Store lanes come straight from the request; load lanes from the latched op.
  mem_lane_align u_align (
    .st_funct3 (req_funct3),
    .st_lane   (req_addr[1:0]),
    .st_data   (req_wdata),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (op_funct3),
    .ld_lane   (op_lane),
    .ld_rdata  (bus_rdata),
    .ld_value  (ld_value)
  );

  // Transaction controller; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
      err       <= 1'b0;
      op_load   <= 1'b0;
      op_funct3 <= 3'b000;
      op_lane   <= 2'b00;
      op_rd     <= 5'd0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          // Requests with no op bit set are swallowed without leaving IDLE.
          if (req_valid && (req_load || req_store)) begin
            req_ready <= 1'b0;
            op_load   <= req_load;
            op_funct3 <= req_funct3;
            op_lane   <= req_addr[1:0];
            op_rd     <= req_rd;
            if (bad_req) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state     <= BUS;
              bus_valid <= 1'b1;
              bus_we    <= req_store;
              bus_be    <= req_store ? st_be : 4'b1111;
              bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              bus_wdata <= req_store ? st_wdata : 32'h0;
`ifdef MEM_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_valid <= 1'b0;
            if (op_load) begin
              state    <= RESP;
              wb_valid <= (op_rd != 5'd0);
              wb_rd    <= op_rd;
              wb_data  <= ld_value;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            bus_valid <= 1'b0;
            state     <= ERR;
            err       <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
